alu_share_arbiter: RTL
======================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational integer ALU between NUM_REQ requesters (e.g. main
//  issue pipe, branch/CSR helper, address-gen side path). Round-robin grant, one
//  operation accepted per cycle, ALU result captured into a single response
//  register and returned to the winner with a valid/ready handshake.
//  Sits between requester-side operand buses and the ALU + ALU-op decode path.
// PARAMETERS
//  NUM_REQ     2   number of requesters (>=2, <=8)
//  DATA_WIDTH  32  operand/result width
//  OP_WIDTH    4   ALU operation code width (4-bit ALU op encoding)
// PORTS
//  clk           in   1                   clock, all state on rising edge
//  rst           in   1                   synchronous, active-high reset
//  req_valid_i   in   NUM_REQ             requester i has an op pending
//  req_ready_o   out  NUM_REQ             one-hot grant; accept when valid&ready
//  req_op_i      in   NUM_REQ*OP_WIDTH    ALU op per requester (slice i)
//  req_a_i       in   NUM_REQ*DATA_WIDTH  operand A per requester
//  req_b_i       in   NUM_REQ*DATA_WIDTH  operand B per requester
//  resp_valid_o  out  NUM_REQ             one-hot: result for requester i ready
//  resp_ready_i  in   NUM_REQ             requester i consumes result
//  resp_data_o   out  DATA_WIDTH          registered ALU result (shared bus)
//  resp_zero_o   out  1                   registered ALU zero flag
//  alu_op_o      out  OP_WIDTH            to ALU: op of current grant
//  alu_a_o       out  DATA_WIDTH          to ALU: operand A of current grant
//  alu_b_o       out  DATA_WIDTH          to ALU: operand B of current grant
//  alu_result_i  in   DATA_WIDTH          from ALU, combinational same cycle
//  alu_zero_i    in   1                   from ALU, combinational same cycle
// BEHAVIOUR
//  - Two states: IDLE (response register empty), RESP (holds result for owner).
//  - can_accept = (state==IDLE) | (state==RESP & resp_ready_i[owner]).
//  - Grant: when can_accept, rotate-priority pick among req_valid_i starting at
//    rr_ptr; req_ready_o = one-hot winner, else all zero. Ready never asserted
//    for a requester whose valid is low.
//  - ALU drive: alu_* = winner's slices when a grant exists, else all zero.
//  - Accept (valid&ready): capture alu_result_i/alu_zero_i into resp register,
//    owner<=winner, state<=RESP, rr_ptr<=(winner+1) mod NUM_REQ.
//  - Latency: accept in cycle T -> resp_valid_o[owner] high from T+1.
//  - RESP: resp_valid_o[owner] held with stable data until resp_ready_i[owner];
//    resp_ready_i of non-owners ignored. On consume with no new accept -> IDLE,
//    resp_valid_o all zero next cycle.
//  - Simultaneous consume + accept: back-to-back, new result visible next cycle;
//    full throughput of one op/cycle with ready held high.
//  - Same requester may win consecutive cycles only if it is the sole valid one.
//  - No requests: state, rr_ptr unchanged; alu_* zero.
//  - rr_ptr wrap: NUM_REQ-1 -> 0. Non-power-of-2 NUM_REQ supported.
//  - Reset (any cycle, incl. mid-RESP): state=IDLE, owner=0, rr_ptr=0,
//    resp_data_o=0, resp_zero_o=0, resp_valid_o=0, req_ready_o=0 during reset;
//    a pending unconsumed result is discarded.
//  - Unknown op codes are passed through unchanged; ALU defines their result.
// STRUCTURE
//  - Shared core package: ALU op code constants (AND..SLT_U, 4-bit) as an
//    enum alu_op_t, DATA_WIDTH default, state enum {IDLE, RESP}.
//  - Sub-module rr_arbiter #(N): combinational rotate-priority pick
//    (req, ptr -> one-hot grant, grant index, any). Top holds FSM, pointer,
//    response register and operand muxes.
// TESTING
//  - Reset: assert rst 2 cycles during RESP -> all outputs 0, state IDLE after.
//  - Single req: r0 valid, op=SUM, a=5, b=7 -> ready[0] cycle T, resp_valid[0]
//    T+1, resp_data=12, zero=0.
//  - Contention: r0,r1 valid every cycle, ready held high, rr_ptr=0 -> grants
//    0,1,0,1...; SUB a=3,b=3 on r1 -> resp_data=0, zero=1.
//  - Backpressure: r0 result, resp_ready[0]=0 for 4 cycles -> data stable, no
//    grants; r1 raises resp_ready -> ignored; then consume+new req same cycle
//    -> accepted, no bubble.
//  - Wrap NUM_REQ=3: only r2 then r0 valid -> grant 2, rr_ptr wraps to 0,
//    grant 0; SHIFT_LEFT a=1,b=31 -> 0x8000_0000.
//  - Idle: no valid for 10 cycles -> alu_*=0, req_ready=0, rr_ptr unchanged.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALU op encoding, defaults and FSM states.
package alu_share_arbiter_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int ALU_OP_WIDTH       = 4;

  typedef enum logic [3:0] {
    ALU_AND           = 4'd0,
    ALU_OR            = 4'd1,
    ALU_XOR           = 4'd2,
    ALU_SUM           = 4'd3,
    ALU_SUB           = 4'd4,
    ALU_SHIFT_LEFT    = 4'd5,
    ALU_SHIFT_RIGHT   = 4'd6,
    ALU_SHIFT_RIGHT_A = 4'd7,
    ALU_SLT           = 4'd8,
    ALU_SLT_U         = 4'd9
  } alu_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational rotate-priority arbiter: the first requester at or after ptr
// (wrapping modulo N) wins.
module rr_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant,
// one op per cycle, result held in a single response register for its owner.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OP_WIDTH   = ALU_OP_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b_i,
  output logic [NUM_REQ-1:0]             resp_valid_o,
  input  logic [NUM_REQ-1:0]             resp_ready_i,
  output logic [DATA_WIDTH-1:0]          resp_data_o,
  output logic                           resp_zero_o,
  output logic [OP_WIDTH-1:0]            alu_op_o,
  output logic [DATA_WIDTH-1:0]          alu_a_o,
  output logic [DATA_WIDTH-1:0]          alu_b_o,
  input  logic [DATA_WIDTH-1:0]          alu_result_i,
  input  logic                           alu_zero_i
);

  localparam int IW = $clog2(NUM_REQ);

  state_t                state_reg, state_next;
  logic [IW-1:0]         owner_reg;
  logic [IW-1:0]         rr_ptr_reg;
  logic [DATA_WIDTH-1:0] resp_data_reg;
  logic                  resp_zero_reg;

  logic [OP_WIDTH-1:0]   op_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] a_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr  [NUM_REQ];

  logic                  can_accept;
  logic [NUM_REQ-1:0]    arb_req;
  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         win_idx;
  logic                  grant_any;
  logic [IW-1:0]         ptr_next;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign op_arr[gi]       = req_op_i[gi*OP_WIDTH +: OP_WIDTH];
      assign a_arr[gi]        = req_a_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign b_arr[gi]        = req_b_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign resp_valid_o[gi] = (state_reg == RESP) && (owner_reg == IW'(gi)) && !rst;
    end
  endgenerate

  // A new op may enter only when the response register is free or being drained now.
  assign can_accept = (state_reg == IDLE) || resp_ready_i[owner_reg];
  assign arb_req    = req_valid_i & {NUM_REQ{can_accept && !rst}};

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (arb_req),
    .ptr       (rr_ptr_reg),
    .grant     (grant),
    .grant_idx (win_idx),
    .any       (grant_any)
  );

  assign req_ready_o = grant;
  assign alu_op_o    = grant_any ? op_arr[win_idx] : '0;
  assign alu_a_o     = grant_any ? a_arr[win_idx]  : '0;
  assign alu_b_o     = grant_any ? b_arr[win_idx]  : '0;
  assign ptr_next    = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  always_comb begin
    state_next = state_reg;
    if (grant_any) begin
      state_next = RESP;
    end else if (state_reg == RESP && resp_ready_i[owner_reg]) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg     <= '0;
      rr_ptr_reg    <= '0;
      resp_data_reg <= '0;
      resp_zero_reg <= 1'b0;
    end else if (grant_any) begin
      owner_reg     <= win_idx;
      rr_ptr_reg    <= ptr_next;
      resp_data_reg <= alu_result_i;
      resp_zero_reg <= alu_zero_i;
    end
  end

  assign resp_data_o = resp_data_reg;
  assign resp_zero_o = resp_zero_reg;

endmodule
